// File: rtl/fc_output_neurons.sv
// Output layer of the FC classifier: 10 neurons, each a signed 16x16 MAC over N_IN features plus bias.
// Streams addresses 0..N_IN to synchronous-read buffers; results and a level done land N_IN+2 edges after start.
module fc_output_neurons #(
  parameter int N_IN      = 84,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 40,
  parameter int ADDR_W    = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       feat_data,
  input  logic [159:0]      wgt_data,
  output logic              busy,
  output logic              done,
  output logic [15:0]       out0,
  output logic [15:0]       out1,
  output logic [15:0]       out2,
  output logic [15:0]       out3,
  output logic [15:0]       out4,
  output logic [15:0]       out5,
  output logic [15:0]       out6,
  output logic [15:0]       out7,
  output logic [15:0]       out8,
  output logic [15:0]       out9
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_IN);

  state_t                   state_q, state_d;
  logic                     rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     vld_q, vld_d;
  logic                     bias_q, bias_d;
  logic signed [ACC_W-1:0]  acc_q [10];
  logic signed [ACC_W-1:0]  acc_d [10];
  logic [15:0]              out_q [10];
  logic [15:0]              out_d [10];

  logic                     clear;
  logic signed [31:0]       prod    [10];
  logic signed [ACC_W-1:0]  shifted [10];
  logic [ACC_W:0]           sum     [10];

  always_comb begin
    state_d   = state_q;
    rd_en_d   = rd_en_q;
    rd_addr_d = rd_addr_q;
    busy_d    = busy_q;
    done_d    = done_q;
    clear     = 1'b0;
    // Read data trails the strobe by one cycle; the bias word is tagged by its address.
    vld_d     = rd_en_q;
    bias_d    = rd_en_q && (rd_addr_q == LAST_ADDR);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ISSUE;
          rd_addr_d = '0;
          rd_en_d   = 1'b1;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          clear     = 1'b1;
        end
      end
      ISSUE: begin
        if (rd_addr_q == LAST_ADDR) begin
          rd_en_d = 1'b0;
          state_d = DRAIN;
        end else begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (vld_q && bias_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    for (int j = 0; j < 10; j++) begin
      acc_d[j]   = acc_q[j];
      out_d[j]   = out_q[j];
      prod[j]    = $signed(feat_data) * $signed(wgt_data[16*j +: 16]);
      shifted[j] = acc_q[j] >>> FRAC_BITS;
      sum[j]     = {shifted[j][ACC_W-1], shifted[j]}
                 + {{(ACC_W-15){wgt_data[16*j+15]}}, wgt_data[16*j +: 16]};
      if (clear) begin
        acc_d[j] = '0;
      end else if (vld_q && !bias_q) begin
        acc_d[j] = acc_q[j] + {{(ACC_W-32){prod[j][31]}}, prod[j]};
      end
      if (vld_q && bias_q) begin
        // In range iff every bit above bit 15 matches the sign.
        if (&sum[j][ACC_W:15] || ~|sum[j][ACC_W:15]) begin
          out_d[j] = sum[j][15:0];
        end else begin
          out_d[j] = sum[j][ACC_W] ? 16'h8000 : 16'h7FFF;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      vld_q     <= 1'b0;
      bias_q    <= 1'b0;
      for (int j = 0; j < 10; j++) begin
        acc_q[j] <= '0;
        out_q[j] <= '0;
      end
    end else begin
      state_q   <= state_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      vld_q     <= vld_d;
      bias_q    <= bias_d;
      for (int j = 0; j < 10; j++) begin
        acc_q[j] <= acc_d[j];
        out_q[j] <= out_d[j];
      end
    end
  end

  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign out0    = out_q[0];
  assign out1    = out_q[1];
  assign out2    = out_q[2];
  assign out3    = out_q[3];
  assign out4    = out_q[4];
  assign out5    = out_q[5];
  assign out6    = out_q[6];
  assign out7    = out_q[7];
  assign out8    = out_q[8];
  assign out9    = out_q[9];

endmodule

// File: tb/tb_fc_output_neurons.sv
// Directed bench for fc_output_neurons: a small N_IN=4 instance for hand-computed vectors
// and a default-parameter instance checked against a floor/saturate reference model.
module tb_fc_output_neurons;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic sel;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Small instance, N_IN = 4
  logic         start_a, rd_en_a, busy_a, done_a;
  logic [6:0]   rd_addr_a;
  logic [15:0]  feat_a;
  logic [159:0] wgt_a;
  logic [15:0]  a0, a1, a2, a3, a4, a5, a6, a7, a8, a9;
  logic [15:0]  fa [0:4];
  logic [159:0] wa [0:4];

  // Default instance, N_IN = 84
  logic         start_b, rd_en_b, busy_b, done_b;
  logic [6:0]   rd_addr_b;
  logic [15:0]  feat_b;
  logic [159:0] wgt_b;
  logic [15:0]  b0, b1, b2, b3, b4, b5, b6, b7, b8, b9;
  logic [15:0]  fb [0:84];
  logic [159:0] wb [0:84];

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  fc_output_neurons #(.N_IN(4), .FRAC_BITS(8), .ACC_W(40), .ADDR_W(7)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
    .feat_data(feat_a), .wgt_data(wgt_a), .busy(busy_a), .done(done_a),
    .out0(a0), .out1(a1), .out2(a2), .out3(a3), .out4(a4),
    .out5(a5), .out6(a6), .out7(a7), .out8(a8), .out9(a9)
  );

  fc_output_neurons dut_b (
    .clk(clk), .reset(reset), .start(start_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
    .feat_data(feat_b), .wgt_data(wgt_b), .busy(busy_b), .done(done_b),
    .out0(b0), .out1(b1), .out2(b2), .out3(b3), .out4(b4),
    .out5(b5), .out6(b6), .out7(b7), .out8(b8), .out9(b9)
  );

  // Synchronous-read buffers
  always @(posedge clk) begin
    if (rd_en_a && rd_addr_a <= 7'd4) begin
      feat_a <= fa[rd_addr_a];
      wgt_a  <= wa[rd_addr_a];
    end
    if (rd_en_b && rd_addr_b <= 7'd84) begin
      feat_b <= fb[rd_addr_b];
      wgt_b  <= wb[rd_addr_b];
    end
  end

  logic [9:0][15:0] oa, ob, os;
  logic             rd_en_s, done_s, busy_s;
  logic [6:0]       rd_addr_s;
  assign oa        = {a9, a8, a7, a6, a5, a4, a3, a2, a1, a0};
  assign ob        = {b9, b8, b7, b6, b5, b4, b3, b2, b1, b0};
  assign os        = sel ? ob : oa;
  assign rd_en_s   = sel ? rd_en_b : rd_en_a;
  assign rd_addr_s = sel ? rd_addr_b : rd_addr_a;
  assign done_s    = sel ? done_b : done_a;
  assign busy_s    = sel ? busy_b : busy_a;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load_a(input logic [15:0] f, input logic [15:0] w, input bit ramp,
                        input logic [15:0] bias);
    for (int k = 0; k < 4; k++) begin
      fa[k] = f;
      for (int j = 0; j < 10; j++) wa[k][16*j +: 16] = ramp ? 16'(j * w) : w;
    end
    fa[4] = 16'h0;
    for (int j = 0; j < 10; j++) wa[4][16*j +: 16] = bias;
  endtask

  // Launch one run on the selected instance and watch it until done or the budget expires.
  task automatic run(input bit mid_start, output int lat, output int nrd, output bit addr_ok,
                     output bit hold_ok, output bit done0);
    logic [9:0][15:0] old;
    old     = os;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    done0   = done_s;
    lat     = -1;
    nrd     = 0;
    addr_ok = 1'b1;
    hold_ok = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (rd_en_s) begin
        if (rd_addr_s != 7'(nrd)) addr_ok = 1'b0;
        nrd++;
      end
      if (done_s) begin
        lat = i;
        break;
      end
      if (os != old) hold_ok = 1'b0;
      start = mid_start && (i == 2);
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  int               lat, nrd;
  bit               addr_ok, hold_ok, done0;
  logic [15:0]      exp_b [10];
  longint           acc, s;
  int               mi, di;

  initial begin
    sel   = 1'b0;
    start = 1'b0;
    reset = 1'b1;
    load_a(16'h0100, 16'h0100, 1'b1, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_en", 32'(rd_en_a), 0);
    check("rst_rd_addr", 32'(rd_addr_a), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_outs", 32'(|oa), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic run: out_j = j * 4.0
    run(1'b0, lat, nrd, addr_ok, hold_ok, done0);
    check("basic_lat", 32'(lat), 6);
    check("basic_nrd", 32'(nrd), 5);
    check("basic_addr_seq", 32'(addr_ok), 1);
    check("basic_busy_end", 32'(busy_a), 0);
    for (int j = 0; j < 10; j++) check($sformatf("basic_out%0d", j), 32'(oa[j]), 32'(j * 16'h0400));

    // Reset mid-run
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_rd_en", 32'(rd_en_a), 0);
    check("midrst_rd_addr", 32'(rd_addr_a), 0);
    check("midrst_busy", 32'(busy_a), 0);
    check("midrst_done", 32'(done_a), 0);
    check("midrst_outs", 32'(|oa), 0);
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("midrst_no_done", 32'(done_a), 0);

    // Saturation high and low
    load_a(16'h7FFF, 16'h7FFF, 1'b0, 16'h0000);
    run(1'b0, lat, nrd, addr_ok, hold_ok, done0);
    check("sat_hi_lat", 32'(lat), 6);
    for (int j = 0; j < 10; j += 3) check($sformatf("sat_hi_out%0d", j), 32'(oa[j]), 32'h7FFF);
    load_a(16'h7FFF, 16'h8001, 1'b0, 16'h0000);
    run(1'b0, lat, nrd, addr_ok, hold_ok, done0);
    for (int j = 0; j < 10; j += 3) check($sformatf("sat_lo_out%0d", j), 32'(oa[j]), 32'h8000);

    // Floor toward -inf, then bias
    load_a(16'hFFFF, 16'h0001, 1'b0, 16'h0000);
    run(1'b0, lat, nrd, addr_ok, hold_ok, done0);
    check("floor_out0", 32'(oa[0]), 32'hFFFF);
    check("floor_out9", 32'(oa[9]), 32'hFFFF);
    load_a(16'hFFFF, 16'h0001, 1'b0, 16'h0002);
    run(1'b0, lat, nrd, addr_ok, hold_ok, done0);
    check("bias_out0", 32'(oa[0]), 32'h0001);
    check("bias_out9", 32'(oa[9]), 32'h0001);

    // Start pulsed mid-run is ignored; done drops on launch; outputs hold until the final edge
    load_a(16'h0100, 16'h0100, 1'b1, 16'h0000);
    run(1'b1, lat, nrd, addr_ok, hold_ok, done0);
    check("hs_done_drop", 32'(done0), 0);
    check("hs_hold_old", 32'(hold_ok), 1);
    check("hs_lat", 32'(lat), 6);
    check("hs_nrd", 32'(nrd), 5);
    check("hs_addr_seq", 32'(addr_ok), 1);
    check("hs_out9", 32'(oa[9]), 32'h2400);
    check("hs_out3", 32'(oa[3]), 32'h0C00);
    repeat (4) @(posedge clk);
    #1;
    check("hs_done_level", 32'(done_a), 1);
    check("hs_out9_held", 32'(oa[9]), 32'h2400);

    // Default parameters with random data
    sel = 1'b1;
    for (int k = 0; k < 84; k++) begin
      fb[k] = 16'($urandom_range(0, 32'h200)) - 16'h0100;
      for (int j = 0; j < 10; j++)
        wb[k][16*j +: 16] = (j == 8) ? 16'($urandom) : 16'($urandom_range(0, 32'h200)) - 16'h0100;
    end
    fb[84] = 16'h0;
    for (int j = 0; j < 10; j++) wb[84][16*j +: 16] = 16'($urandom_range(0, 32'h400)) - 16'h0200;
    for (int j = 0; j < 10; j++) begin
      acc = 0;
      for (int k = 0; k < 84; k++)
        acc += longint'($signed(fb[k])) * longint'($signed(wb[k][16*j +: 16]));
      s = (acc >>> 8) + longint'($signed(wb[84][16*j +: 16]));
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      exp_b[j] = 16'(s);
    end
    run(1'b0, lat, nrd, addr_ok, hold_ok, done0);
    check("dflt_lat", 32'(lat), 86);
    check("dflt_nrd", 32'(nrd), 85);
    check("dflt_addr_seq", 32'(addr_ok), 1);
    for (int j = 0; j < 10; j++) check($sformatf("dflt_out%0d", j), 32'(ob[j]), 32'(exp_b[j]));
    mi = 0;
    di = 0;
    for (int j = 1; j < 10; j++) begin
      if ($signed(exp_b[j]) > $signed(exp_b[mi])) mi = j;
      if ($signed(ob[j]) > $signed(ob[di])) di = j;
    end
    check("dflt_argmax", 32'(di), 32'(mi));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
